rr_mux_arbiter: RTL
===================

Name: rr_mux_arbiter

Overview:
Round-robin arbiter and sequencer for a 4:1 DATA_W-bit mux datapath. It shares a single output channel between four requesters (in1..in4) and drives the mux select from the current grant. Ownership is held for a bounded burst under a valid/ready output handshake. It sits between four producer blocks and one downstream consumer.

Parameters:
- DATA_W, 2, width of each data input and of out.
- MAX_BURST, 4, maximum accepted transfers per grant before forced rotation; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  4  request per source; req[0] = in1 … req[3] = in4.
- in1  input  DATA_W  source 0 data.
- in2  input  DATA_W  source 1 data.
- in3  input  DATA_W  source 2 data.
- in4  input  DATA_W  source 3 data.
- out_ready  input  1  consumer accepts out this cycle.
- out_valid  output  1  out carries granted source data.
- out  output  DATA_W  muxed data.
- select  output  2  binary index of the granted source; 0 = in1 … 3 = in4.
- grant  output  4  one-hot registered grant; 0000 when idle.
- ack  output  4  one-hot per-source transfer strobe.

Behaviour:
- Reset (async, any time, including mid-burst):
  - state=IDLE, grant=0000, select=00, ptr=0, cnt=0.
  - out_valid=0, out=0, ack=0000.
  - No transfer completes in a cycle where rst is high.
- Registered state: state {IDLE, GRANT}, grant/select, ptr (2-bit rotation start), cnt (burst counter, width clog2(MAX_BURST+1)).
- Arbitration function pick(r, p): first set bit of r, searching indices p, p+1, … mod 4.
- IDLE:
  - If req != 0, next edge: GRANT, select=pick(req, ptr), grant=onehot(select), cnt=0.
  - Latency is 1 cycle from req sample to grant.
- GRANT (combinational outputs):
  - out_valid = req[select].
  - out = mux(select) when out_valid, else 0.
  - ack[select] = out_valid & out_ready; all other ack bits are 0.
- Transfer: out_valid & out_ready; cnt increments on each transfer.
- Release occurs when either:
  - req[select]==0, or
  - a transfer occurs with cnt==MAX_BURST-1.
- On release:
  - ptr = select+1 (mod 4).
  - If req (current cycle) has any bit set, re-grant directly to pick(req, select+1) with cnt=0 and no idle gap. The releasing source is lowest priority, but it is re-granted if it is the sole requester.
  - Otherwise go to IDLE with grant=0000 and select unchanged.
- No release while out_valid & !out_ready: grant, select, out and cnt hold (backpressure).
- Requests of non-granted sources never preempt an active grant.
- Wrap-around: ptr rolls 3 -> 0. cnt never exceeds MAX_BURST-1.
- MAX_BURST=1: rotation after every transfer.
- grant is always one-hot or zero; select always equals the index of the grant bit while in GRANT.

Test Plan:
- Reset: rst=1 mid-operation -> same cycle out_valid=0, out=00, grant=0000, ack=0000; after release with req=1111, first grant=0001.
- Single source: in3=10, req=0100, out_ready=1 -> next cycle grant=0100, select=10, out=10, out_valid=1. Four acks on ack[2], then direct re-grant to 0100 with cnt reset and no gap.
- Full contention: in1..in4 = 00, 01, 10, 11; req=1111; out_ready=1; MAX_BURST=4 -> out sequence 00x4, 01x4, 10x4, 11x4, 00x4…; grant 0001 -> 0010 -> 0100 -> 1000 -> 0001.
- Backpressure: granted source 1, out_ready=0 for 5 cycles -> grant=0010, out=01 stable, ack=0000, cnt frozen; resumes counting when out_ready=1.
- Early drop: req=0011, source 0 drops req after 2 transfers -> next edge grant=0010, select=01, cnt=0.
- Idle return: sole requester drops req -> next cycle grant=0000, out_valid=0. New req=1000 -> grant=1000 one cycle later.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for a 4:1 mux datapath with bounded bursts under a
// valid/ready output handshake.
module rr_mux_arbiter #(
  parameter int unsigned DATA_W    = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic [1:0]        select,
  output logic [3:0]        grant,
  output logic [3:0]        ack
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q;
  logic [3:0]     grant_q;
  logic [1:0]     sel_q;
  logic [1:0]     ptr_q;
  logic [CW-1:0]  cnt_q;

  logic           xfer;
  logic           release_g;
  logic [1:0]     pick_idle;
  logic [1:0]     pick_next;
  logic [1:0]     sel_inc;
  logic [DATA_W-1:0] mux_data;

  // First set bit of r searching p, p+1, ... mod 4; lowest offset wins.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int unsigned i = 4; i > 0; i--) begin
      idx = p + 2'(i - 1);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    mux_data = in1;
    unique case (sel_q)
      2'd0: mux_data = in1;
      2'd1: mux_data = in2;
      2'd2: mux_data = in3;
      2'd3: mux_data = in4;
    endcase
  end

  assign out_valid = (state_q == GRANT) && req[sel_q];
  assign out       = out_valid ? mux_data : '0;
  assign xfer      = out_valid && out_ready;
  assign ack       = xfer ? grant_q : '0;
  assign grant     = grant_q;
  assign select    = sel_q;

  assign sel_inc   = sel_q + 2'd1;
  assign pick_idle = pick(req, ptr_q);
  assign pick_next = pick(req, sel_inc);
  assign release_g = !req[sel_q] || (xfer && (cnt_q == CW'(MAX_BURST - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            sel_q   <= pick_idle;
            grant_q <= 4'b0001 << pick_idle;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (release_g) begin
            ptr_q <= sel_inc;
            cnt_q <= '0;
            // Releasing source ends up lowest priority but may win again if alone.
            if (|req) begin
              sel_q   <= pick_next;
              grant_q <= 4'b0001 << pick_next;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end else if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
